// File: rtl/vga_pkg.sv
// Shared screen geometry, colour constants and arbiter state encoding
// for the snake game's VGA pixel path.
package vga_pkg;

  localparam int SCREEN_X_MAX = 159;
  localparam int SCREEN_Y_MAX = 119;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] BLUE  = 3'b001;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] WHITE = 3'b111;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/vga_plot_arbiter_if.sv
// Requester-side pixel bus. Per requester i: a pixel moves in a cycle where
// req_valid[i] & req_ready[i]; valid must not wait for ready, ready may depend on valid.
interface vga_plot_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_lock;
    logic [8*NUM_REQ-1:0] req_x;
    logic [7*NUM_REQ-1:0] req_y;
    logic [3*NUM_REQ-1:0] req_colour;
    logic [NUM_REQ-1:0]   req_ready;

    modport master (
        output req_valid, req_lock, req_x, req_y, req_colour,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_lock, req_x, req_y, req_colour,
        output req_ready
    );
endinterface

// File: rtl/vga_plot_arbiter_rr_pick.sv
// Combinational round-robin search: first set valid bit at or above ptr, wrapping.
module vga_plot_arbiter_rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && valid[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
            // explicit wrap so non-power-of-two NUM_REQ works
            cand = (cand == IDX_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
        end
    end
endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter with optional grant lock feeding the single vga_adapter
// pixel port through a registered, off-screen-clipping output stage.
module vga_plot_arbiter
    import vga_pkg::*;
#(
    parameter  int NUM_REQ      = 4,
    parameter  int X_MAX        = SCREEN_X_MAX,
    parameter  int Y_MAX        = SCREEN_Y_MAX,
    parameter  int LOCK_TIMEOUT = 255,
    localparam int IDX_W        = $clog2(NUM_REQ),
    localparam int CNT_W        = $clog2(LOCK_TIMEOUT + 1)
) (
    input  logic                clk,
    input  logic                reset,
    vga_plot_arbiter_if.slave   bus,
    output logic [7:0]          x,
    output logic [6:0]          y,
    output logic [2:0]          colour,
    output logic                plot,
    output logic [IDX_W-1:0]    owner,
    output logic                locked,
    output logic [15:0]         drop_count
);
    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [IDX_W-1:0]   win;
    logic               xfer;
    logic               win_lock;
    logic [7:0]         win_x;
    logic [6:0]         win_y;
    logic [2:0]         win_c;
    logic               in_range;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

    vga_plot_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .valid (bus.req_valid),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        bus.req_ready = '0;
        if (state_q == ARB) bus.req_ready = pick_grant;
        else                bus.req_ready[owner] = bus.req_valid[owner];
    end

    assign win      = (state_q == ARB) ? pick_idx : owner;
    assign xfer     = (state_q == ARB) ? pick_any : bus.req_valid[owner];
    assign win_lock = bus.req_lock[win];
    assign win_x    = bus.req_x[int'(win)*8 +: 8];
    assign win_y    = bus.req_y[int'(win)*7 +: 7];
    assign win_c    = bus.req_colour[int'(win)*3 +: 3];
    assign in_range = (win_x <= 8'(X_MAX)) && (win_y <= 7'(Y_MAX));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB: begin
                if (xfer) begin
                    if (win_lock) state_d = LOCKED;
                    else          ptr_d   = next_idx(win);
                end
            end
            LOCKED: begin
                // a transfer always beats timeout expiry in the same cycle
                if (xfer) begin
                    cnt_d = '0;
                    if (!win_lock) begin
                        state_d = ARB;
                        ptr_d   = next_idx(owner);
                    end
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    state_d = ARB;
                    ptr_d   = next_idx(owner);
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ARB;
            ptr_q      <= '0;
            cnt_q      <= '0;
            owner      <= '0;
            x          <= '0;
            y          <= '0;
            colour     <= '0;
            plot       <= 1'b0;
            drop_count <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            plot    <= 1'b0;
            if (xfer) begin
                owner <= win;
                if (in_range) begin
                    x      <= win_x;
                    y      <= win_y;
                    colour <= win_c;
                    plot   <= 1'b1;
                end else if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end
        end
    end

    assign locked = (state_q == LOCKED);
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter: stimulus pushes expected pixels,
// a negedge monitor pops and compares on every plot strobe.
`timescale 1ns/1ps
module tb_vga_plot_arbiter;
  import vga_pkg::*;

  localparam int NREQ = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vga_plot_arbiter_if #(.NUM_REQ(NREQ)) bus ();

  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic [1:0]  owner;
  logic        locked;
  logic [15:0] drop_count;

  vga_plot_arbiter #(
    .NUM_REQ(NREQ), .X_MAX(159), .Y_MAX(119), .LOCK_TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .x(x), .y(y), .colour(colour), .plot(plot),
    .owner(owner), .locked(locked), .drop_count(drop_count)
  );

  // scoreboard
  logic [17:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && plot) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0d with nothing expected at %0t",
                 x, y, colour, $time);
      end else begin
        chk("pixel", {14'd0, x, y, colour}, {14'd0, exp_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic clear_all();
    bus.req_valid  = '0;
    bus.req_lock   = '0;
    bus.req_x      = '0;
    bus.req_y      = '0;
    bus.req_colour = '0;
  endtask

  task automatic set_req(input int i, input logic v, input logic l,
                         input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc);
    bus.req_valid[i]        = v;
    bus.req_lock[i]         = l;
    bus.req_x[i*8 +: 8]     = px;
    bus.req_y[i*7 +: 7]     = py;
    bus.req_colour[i*3 +: 3] = pc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_x"}, {24'd0, x}, 32'd0);
    chk({tag, "_y"}, {25'd0, y}, 32'd0);
    chk({tag, "_colour"}, {29'd0, colour}, 32'd0);
    chk({tag, "_plot"}, {31'd0, plot}, 32'd0);
    chk({tag, "_owner"}, {30'd0, owner}, 32'd0);
    chk({tag, "_locked"}, {31'd0, locked}, 32'd0);
    chk({tag, "_drop"}, {16'd0, drop_count}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [3:0] t2_rdy [4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
  logic       t3_lock [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  logic       t3_lkd  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  logic [7:0] t5_x [3] = '{8'd160, 8'd5, 8'd159};
  logic [6:0] t5_y [3] = '{7'd10, 7'd120, 7'd119};
  logic [2:0] t5_c [3] = '{3'b111, 3'b001, 3'b010};

  initial begin
    reset = 1'b1;
    clear_all();
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    reset = 1'b0;

    // 1: idle
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("idle_ready", {28'd0, bus.req_ready}, 32'd0);
      chk("idle_plot", {31'd0, plot}, 32'd0);
      step();
    end
    chk("idle_drop", {16'd0, drop_count}, 32'd0);

    // 2: req0 and req2 alternate
    for (int k = 0; k < 4; k++) begin
      set_req(0, 1'b1, 1'b0, 8'(10 + k), 7'd20, BLUE);
      set_req(2, 1'b1, 1'b0, 8'(30 + k), 7'd40, RED);
      @(negedge clk);
      chk("rr_ready", {28'd0, bus.req_ready}, {28'd0, t2_rdy[k]});
      if (k % 2 == 0) exp_q.push_back({8'(10 + k), 7'd20, BLUE});
      else            exp_q.push_back({8'(30 + k), 7'd40, RED});
      step();
    end
    clear_all();
    @(negedge clk);
    chk("rr_owner", {30'd0, owner}, 32'd2);
    step();

    // move pointer to 1
    set_req(0, 1'b1, 1'b0, 8'd1, 7'd1, WHITE);
    @(negedge clk);
    chk("bridge_ready", {28'd0, bus.req_ready}, 32'h1);
    exp_q.push_back({8'd1, 7'd1, WHITE});
    step();
    clear_all();

    // 3: req1 locked run, req0 waiting
    for (int k = 0; k < 4; k++) begin
      set_req(1, 1'b1, t3_lock[k], 8'(50 + k), 7'd60, GREEN);
      set_req(0, 1'b1, 1'b0, 8'd70, 7'd71, WHITE);
      @(negedge clk);
      chk("lock_ready", {28'd0, bus.req_ready}, 32'h2);
      chk("lock_locked", {31'd0, locked}, {31'd0, t3_lkd[k]});
      exp_q.push_back({8'(50 + k), 7'd60, GREEN});
      step();
    end
    set_req(1, 1'b0, 1'b0, 8'd0, 7'd0, BLACK);
    @(negedge clk);
    chk("unlock_ready", {28'd0, bus.req_ready}, 32'h1);
    chk("unlock_locked", {31'd0, locked}, 32'd0);
    exp_q.push_back({8'd70, 7'd71, WHITE});
    step();
    clear_all();

    // 4: req3 locks then goes idle; timeout 8
    set_req(3, 1'b1, 1'b1, 8'd100, 7'd101, RED);
    set_req(0, 1'b1, 1'b0, 8'd90, 7'd91, WHITE);
    @(negedge clk);
    chk("to_grant3", {28'd0, bus.req_ready}, 32'h8);
    exp_q.push_back({8'd100, 7'd101, RED});
    step();
    set_req(3, 1'b0, 1'b0, 8'd0, 7'd0, BLACK);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("to_ready", {28'd0, bus.req_ready}, 32'd0);
      chk("to_locked", {31'd0, locked}, 32'd1);
      if (k >= 2) chk("to_plot", {31'd0, plot}, 32'd0);
      step();
    end
    @(negedge clk);
    chk("to_release_ready", {28'd0, bus.req_ready}, 32'h1);
    chk("to_release_locked", {31'd0, locked}, 32'd0);
    chk("to_release_plot", {31'd0, plot}, 32'd0);
    exp_q.push_back({8'd90, 7'd91, WHITE});
    step();
    clear_all();

    // 5: clipping
    for (int k = 0; k < 3; k++) begin
      set_req(0, 1'b1, 1'b0, t5_x[k], t5_y[k], t5_c[k]);
      @(negedge clk);
      chk("clip_ready", {28'd0, bus.req_ready}, 32'h1);
      if (k == 1) begin
        chk("clip_plot0", {31'd0, plot}, 32'd0);
        chk("clip_hold_x", {24'd0, x}, 32'd90);
        chk("clip_drop1", {16'd0, drop_count}, 32'd1);
      end
      if (k == 2) begin
        chk("clip_plot1", {31'd0, plot}, 32'd0);
        chk("clip_drop2", {16'd0, drop_count}, 32'd2);
        exp_q.push_back({8'd159, 7'd119, GREEN});
      end
      step();
    end
    clear_all();
    @(negedge clk);
    chk("clip_edge_plot", {31'd0, plot}, 32'd1);
    chk("clip_drop_final", {16'd0, drop_count}, 32'd2);
    step();

    // 6: reset mid locked run with a transfer in flight
    set_req(1, 1'b1, 1'b1, 8'd20, 7'd21, BLUE);
    @(negedge clk);
    chk("rst_grant1", {28'd0, bus.req_ready}, 32'h2);
    exp_q.push_back({8'd20, 7'd21, BLUE});
    step();
    set_req(1, 1'b1, 1'b1, 8'd22, 7'd23, RED);
    @(negedge clk);
    chk("rst_lock_ready", {28'd0, bus.req_ready}, 32'h2);
    chk("rst_locked", {31'd0, locked}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk_zero_outputs("midrst");
    @(negedge clk);
    chk("midrst_plot_after_edge", {31'd0, plot}, 32'd0);
    step();
    reset = 1'b0;
    clear_all();
    set_req(0, 1'b1, 1'b0, 8'd7, 7'd8, GREEN);
    set_req(3, 1'b1, 1'b0, 8'd9, 7'd9, RED);
    @(negedge clk);
    chk("post_rst_ready", {28'd0, bus.req_ready}, 32'h1);
    exp_q.push_back({8'd7, 7'd8, GREEN});
    step();
    clear_all();
    @(negedge clk);
    chk("post_rst_plot", {31'd0, plot}, 32'd1);
    step();

    repeat (3) step();
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_plot_arbiter.md
Name: vga_plot_arbiter

Overview:
- Shares the single vga_adapter pixel-write port (x, y, colour, plot) between several pixel producers: board setup/clear sweep, snake head/tail painter, food/wrong-food painter, score overlay.
- Round-robin arbitration with a per-requester valid/ready handshake.
- Optional grant lock, so a requester can paint a multi-pixel run uninterrupted.
- Registered output stage with off-screen clipping, sitting between the game datapaths and vga_adapter.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- X_MAX, 159: largest legal x coordinate.
- Y_MAX, 119: largest legal y coordinate.
- LOCK_TIMEOUT, 255: idle cycles a locked owner may hold the grant without presenting valid.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i has a pixel.
- req_lock  in  NUM_REQ  keep the grant after this pixel.
- req_x  in  8*NUM_REQ  packed x, requester i at bits [8i+7:8i].
- req_y  in  7*NUM_REQ  packed y.
- req_colour  in  3*NUM_REQ  packed colour.
- req_ready  out  NUM_REQ  one-hot grant; transfer = valid & ready.
- x  out  8  pixel x to vga_adapter.
- y  out  7  pixel y.
- colour  out  3  pixel colour.
- plot  out  1  write strobe.
- owner  out  clog2(NUM_REQ)  index of the last or current grantee.
- locked  out  1  arbiter is in LOCKED state.
- drop_count  out  16  saturating count of clipped pixels.

Behaviour:
- Reset (asynchronous, active-high) takes effect immediately, mid-transfer or not:
  - x=0, y=0, colour=0, plot=0, owner=0, locked=0, drop_count=0.
  - RR pointer=0, state=ARB, timeout counter=0.
  - The in-flight pixel is discarded.
- State ARB:
  - req_ready is combinational: one-hot of the first set req_valid bit searching upward from the pointer, with wrap-around.
  - req_ready is all zeros when no valid is set.
  - req_ready never asserts for a requester whose valid is low.
- Transfer from winner w:
  - owner<=w.
  - If req_lock[w]=1: go to LOCKED, pointer unchanged.
  - Else: pointer<=(w+1) mod NUM_REQ, stay in ARB.
- State LOCKED:
  - req_ready = one-hot(owner) AND req_valid[owner]. All other readies are 0 regardless of their valid.
  - A transfer with lock=0: pointer<=(owner+1) mod NUM_REQ, return to ARB.
  - A transfer with lock=1: stay in LOCKED and reset the timeout counter.
  - Each cycle with req_valid[owner]=0: timeout counter increments. At LOCK_TIMEOUT, force ARB with pointer<=(owner+1) mod NUM_REQ and counter<=0. This is a forced release, no pixel involved.
- locked output = (state==LOCKED), registered.
- Throughput: one pixel per cycle, including back-to-back transfers from different requesters.
- Output stage:
  - A transfer in cycle N drives x/y/colour and plot in cycle N+1 (latency 1).
  - plot is high for exactly one cycle per in-range transfer.
  - x/y/colour hold their last value while plot=0.
- Clipping:
  - A pixel with x>X_MAX or y>Y_MAX is still accepted (ready, handshake completes, lock semantics apply).
  - It produces plot=0 in N+1, and x/y/colour are not updated.
  - drop_count increments by 1, saturating at 16'hFFFF.
- Simultaneous events:
  - Timeout expiry and a transfer in the same cycle: the transfer wins, and lock semantics apply to it.
  - A requester dropping valid mid-lock does not release the lock before timeout.
- Widths: pointer and owner are clog2(NUM_REQ) bits. Pointer wrap uses explicit compare-to-NUM_REQ-1 (NUM_REQ need not be a power of 2).

Decomposition:
- Shared package vga_pkg holds:
  - SCREEN_X_MAX=159, SCREEN_Y_MAX=119.
  - Colour constants BLACK=3'b000, BLUE=3'b001, GREEN=3'b010, RED=3'b100, WHITE=3'b111.
  - Arbiter state encoding ARB=1'b0, LOCKED=1'b1.
- One natural sub-module, rr_pick: combinational round-robin search, (valid, pointer) -> one-hot grant + index.

Test Plan:
1. Reset then idle, all valid=0 -> ready=0, plot=0 for 20 cycles; drop_count=0.
2. Req0 and req2 valid continuously, lock=0, pointer=0.
   - Grants alternate 0,2,0,2.
   - plot high every cycle from cycle 1.
   - x/y/colour track the granted requester one cycle late.
3. Req1 sends 4 pixels with lock=1,1,1,0 while req0 is valid throughout.
   - req_ready[0]=0 during those 4 transfers; locked=1.
   - Req0 granted on the 5th cycle.
4. Req3 locks, then drops valid, with LOCK_TIMEOUT=8 and req0 valid.
   - Grant released exactly 8 idle cycles later; req0 granted next cycle.
   - No plot during the timeout window.
5. Req0 sends x=160,y=10, then x=5,y=120, then x=159,y=119,colour=3'b010.
   - First two: ready high, plot=0, drop_count=2.
   - Third: plot=1 with x=159, y=119, colour=010.
6. Assert reset during cycle N of a locked run, with a transfer in N.
   - Outputs are zero immediately and plot never rises for that pixel.
   - After release, first grant goes to the lowest-index valid requester (pointer=0).
